// File: rtl/sky130_io_pkg.sv
// rtl/sky130_io_pkg.sv - shared constants for the sky130 pad power-up sequencer
// tech_cfg bit positions, drive-mode encodings, per-pad register layout and sequencer states.
package sky130_io_pkg;

  localparam int TC_HLD_H_N          = 0;
  localparam int TC_ENABLE_H         = 1;
  localparam int TC_ENABLE_INP_H     = 2;
  localparam int TC_ENABLE_VDDA_H    = 3;
  localparam int TC_ENABLE_VSWITCH_H = 4;
  localparam int TC_ENABLE_VDDIO     = 5;
  localparam int TC_IB_MODE_SEL      = 6;
  localparam int TC_VTRIP_SEL        = 7;
  localparam int TC_SLOW             = 8;
  localparam int TC_HLD_OVR          = 9;
  localparam int TC_ANALOG_EN        = 10;
  localparam int TC_ANALOG_SEL       = 11;
  localparam int TC_ANALOG_POL       = 12;
  localparam int TC_DM_LSB           = 13;

  localparam logic [2:0] DM_STRONG = 3'b110;
  localparam logic [2:0] DM_HIZ    = 3'b000;

  // Per-pad register image, same layout as cfg_data[5:0].
  localparam int         CFG_W   = 6;
  localparam logic [5:0] CFG_RST = {DM_STRONG, 3'b000};

  typedef enum logic [1:0] {
    STATE_OFF    = 2'd0,
    STATE_ENABLE = 2'd1,
    STATE_RUN    = 2'd2,
    STATE_HOLD   = 2'd3
  } state_e;

endpackage

// File: rtl/sky130_iobuf_cfgreg.sv
// rtl/sky130_iobuf_cfgreg.sv - one pad's drive-setting register and tech_cfg packer
// The sequencing bits arrive already registered from the top, so every tech_cfg bit is a flop output.
module sky130_iobuf_cfgreg
  import sky130_io_pkg::*;
(
  input  logic             clk,
  input  logic             nreset,
  input  logic             we,
  input  logic [CFG_W-1:0] wdata,
  input  logic             en_h,
  input  logic             hld_h_n,
  output logic [15:0]      tech_cfg
);

  logic [CFG_W-1:0] cfg_q;
  logic [CFG_W-1:0] cfg_d;

  always_comb begin
    cfg_d = cfg_q;
    if (we) cfg_d = wdata;
  end

  always_ff @(posedge clk) begin
    if (!nreset) cfg_q <= CFG_RST;
    else         cfg_q <= cfg_d;
  end

  always_comb begin
    tech_cfg                         = '0;
    tech_cfg[TC_HLD_H_N]             = hld_h_n;
    tech_cfg[TC_ENABLE_H]            = en_h;
    tech_cfg[TC_ENABLE_VDDIO]        = en_h;
    tech_cfg[TC_SLOW]                = cfg_q[0];
    tech_cfg[TC_IB_MODE_SEL]         = cfg_q[1];
    tech_cfg[TC_VTRIP_SEL]           = cfg_q[2];
    tech_cfg[TC_DM_LSB +: 3]         = cfg_q[5:3];
  end

endmodule

// File: rtl/sky130_iobuf_seq.sv
// rtl/sky130_iobuf_seq.sv - power-up sequencer and config register file for sky130 gpiov2 pads
// Orders ENABLE_H before HLD_H_N, supports runtime hold, and accepts per-pad drive writes.
module sky130_iobuf_seq
  import sky130_io_pkg::*;
#(
  parameter int NPINS          = 8,
  parameter int TECH_CFG_WIDTH = 16,
  parameter int EN_DLY         = 16,
  parameter int AW             = 3
) (
  input  logic                            clk,
  input  logic                            nreset,
  input  logic                            pwr_good,
  input  logic                            hold_req,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [AW-1:0]                   cfg_addr,
  input  logic [7:0]                      cfg_data,
  output logic                            cfg_err,
  output logic                            io_ready,
  output logic [NPINS*TECH_CFG_WIDTH-1:0] tech_cfg
);

  localparam int             CW       = $clog2(EN_DLY + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(EN_DLY - 1);
  localparam logic [AW:0]    NPINS_W  = (AW + 1)'(NPINS);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          en_h_q, en_h_d;
  logic          hld_h_n_q, hld_h_n_d;
  logic          cfg_err_q, cfg_err_d;
  logic          wr_en;
  logic          addr_ok;
  logic          unused_rsvd;

  assign cfg_ready   = nreset & (state_q != STATE_ENABLE);
  assign wr_en       = cfg_valid & cfg_ready;
  assign addr_ok     = {1'b0, cfg_addr} < NPINS_W;
  assign io_ready    = (state_q == STATE_RUN);
  assign cfg_err     = cfg_err_q;
  assign unused_rsvd = ^cfg_data[7:6];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      STATE_OFF: begin
        if (pwr_good) begin
          state_d = STATE_ENABLE;
          cnt_d   = '0;
        end
      end
      STATE_ENABLE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = STATE_RUN;
      end
      STATE_RUN:  if (hold_req)  state_d = STATE_HOLD;
      STATE_HOLD: if (!hold_req) state_d = STATE_RUN;
      default:    state_d = STATE_OFF;
    endcase
    // Losing supply beats everything, including a pending hold or a running count.
    if (!pwr_good) begin
      state_d = STATE_OFF;
      cnt_d   = '0;
    end
    en_h_d    = (state_d != STATE_OFF);
    hld_h_n_d = (state_d == STATE_RUN);
    cfg_err_d = wr_en & ~addr_ok;
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q   <= STATE_OFF;
      cnt_q     <= '0;
      en_h_q    <= 1'b0;
      hld_h_n_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      en_h_q    <= en_h_d;
      hld_h_n_q <= hld_h_n_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  for (genvar i = 0; i < NPINS; i++) begin : g_pad
    sky130_iobuf_cfgreg u_cfgreg (
      .clk      (clk),
      .nreset   (nreset),
      .we       (wr_en && (cfg_addr == AW'(i))),
      .wdata    (cfg_data[CFG_W-1:0]),
      .en_h     (en_h_q),
      .hld_h_n  (hld_h_n_q),
      .tech_cfg (tech_cfg[TECH_CFG_WIDTH*i +: TECH_CFG_WIDTH])
    );
  end

endmodule

// File: tb/tb_sky130_iobuf_seq.sv
// tb/tb_sky130_iobuf_seq.sv - self-checking bench for sky130_iobuf_seq
// Age-based reference model checked every cycle, plus directed vectors with literal expectations.
module tb_sky130_iobuf_seq;

  localparam int NPINS  = 8;
  localparam int TCW    = 16;
  localparam int EN_DLY = 16;
  localparam int AW     = 4;

  logic                   clk = 1'b0;
  logic                   nreset;
  logic                   pwr_good;
  logic                   hold_req;
  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [AW-1:0]          cfg_addr;
  logic [7:0]             cfg_data;
  logic                   cfg_err;
  logic                   io_ready;
  logic [NPINS*TCW-1:0]   tech_cfg;

  int checks   = 0;
  int failures = 0;

  sky130_iobuf_seq #(
    .NPINS(NPINS), .TECH_CFG_WIDTH(TCW), .EN_DLY(EN_DLY), .AW(AW)
  ) dut (
    .clk(clk), .nreset(nreset), .pwr_good(pwr_good), .hold_req(hold_req),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_err(cfg_err), .io_ready(io_ready), .tech_cfg(tech_cfg)
  );

  always #5 clk = ~clk;

  // m_age counts edges since ENABLE_H came up; the pad is live once it exceeds EN_DLY.
  bit         m_valid = 1'b0;
  bit         m_pwr   = 1'b0;
  bit         m_held  = 1'b0;
  bit         m_err   = 1'b0;
  int         m_age   = 0;
  logic [5:0] m_reg [NPINS];

  function automatic bit m_live();
    return m_pwr && (m_age > EN_DLY) && !m_held;
  endfunction

  function automatic bit m_ready();
    return nreset && !(m_pwr && m_age <= EN_DLY);
  endfunction

  function automatic logic [15:0] m_pad(int i);
    logic [5:0] r;
    r = m_reg[i];
    return {r[5:3], 4'b0000, r[0], r[2], r[1], m_pwr, 3'b000, m_pwr, m_live()};
  endfunction

  function automatic logic [15:0] pad(int i);
    return tech_cfg[TCW*i +: TCW];
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit rdy;
    bit was_live;
    rdy      = m_ready();
    was_live = m_pwr && (m_age > EN_DLY);
    if (!nreset) begin
      m_valid = 1'b1;
      m_pwr   = 1'b0;
      m_age   = 0;
      m_held  = 1'b0;
      m_err   = 1'b0;
      for (int i = 0; i < NPINS; i++) m_reg[i] = 6'h30;
    end else begin
      m_err = 1'b0;
      if (cfg_valid && rdy) begin
        if (int'(cfg_addr) < NPINS) m_reg[cfg_addr] = cfg_data[5:0];
        else                        m_err = 1'b1;
      end
      if (!pwr_good) begin
        m_pwr  = 1'b0;
        m_age  = 0;
        m_held = 1'b0;
      end else if (!m_pwr) begin
        m_pwr  = 1'b1;
        m_age  = 1;
        m_held = 1'b0;
      end else begin
        m_held = was_live ? hold_req : 1'b0;
        if (m_age <= EN_DLY) m_age++;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("io_ready", 32'(io_ready), 32'(m_live()));
      chk("cfg_ready", 32'(cfg_ready), 32'(m_ready()));
      chk("cfg_err", 32'(cfg_err), 32'(m_err));
      for (int i = 0; i < NPINS; i++)
        chk($sformatf("tech_cfg_pad%0d", i), 32'(pad(i)), 32'(m_pad(i)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nreset    = 1'b0;
    pwr_good  = 1'b0;
    hold_req  = 1'b0;
    cfg_valid = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    repeat (3) tick();
    chk("rst_pad0", 32'(pad(0)), 32'h0000_C000);
    chk("rst_io_ready", 32'(io_ready), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);

    // Power-up with a write parked on the bus through ENABLE.
    nreset   = 1'b1;
    pwr_good = 1'b1;
    tick();
    chk("en_pad0", 32'(pad(0)), 32'h0000_C022);
    chk("en_cfg_ready", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b1;
    cfg_addr  = 4'd1;
    cfg_data  = 8'h05;
    for (int k = 2; k <= 17; k++) begin
      tick();
      if (k == 16) chk("hld_before_17", 32'(pad(0)), 32'h0000_C022);
      if (k == 17) begin
        chk("run_pad0", 32'(pad(0)), 32'h0000_C023);
        chk("run_io_ready", 32'(io_ready), 32'd1);
        chk("run_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("pad1_not_yet", 32'(pad(1)), 32'h0000_C023);
      end
    end
    tick();
    cfg_valid = 1'b0;
    chk("parked_write_pad1", 32'(pad(1)), 32'h0000_01A3);

    // Runtime hold for five cycles.
    hold_req = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("hold_pad0_c%0d", k), 32'(pad(0)), 32'h0000_C022);
    end
    hold_req = 1'b0;
    tick();
    chk("unhold_pad0", 32'(pad(0)), 32'h0000_C023);
    chk("unhold_io_ready", 32'(io_ready), 32'd1);

    cfg_valid = 1'b1;
    cfg_addr  = 4'd2;
    cfg_data  = 8'h09;
    tick();
    cfg_valid = 1'b0;
    chk("wr2_pad2", 32'(pad(2)), 32'h0000_2123);
    chk("wr2_pad0", 32'(pad(0)), 32'h0000_C023);
    chk("wr2_pad1", 32'(pad(1)), 32'h0000_01A3);

    chk("bad_addr_ready", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1;
    cfg_addr  = 4'd8;
    cfg_data  = 8'hFF;
    tick();
    cfg_valid = 1'b0;
    chk("bad_addr_err", 32'(cfg_err), 32'd1);
    chk("bad_addr_pad0", 32'(pad(0)), 32'h0000_C023);
    chk("bad_addr_pad7", 32'(pad(7)), 32'h0000_C023);
    tick();
    chk("bad_addr_err_clr", 32'(cfg_err), 32'd0);

    // Enter HOLD and write pad3 on the same edge, then lose power while held.
    hold_req  = 1'b1;
    cfg_valid = 1'b1;
    cfg_addr  = 4'd3;
    cfg_data  = 8'h3F;
    tick();
    cfg_valid = 1'b0;
    chk("hold_wr_pad3", 32'(pad(3)), 32'h0000_E1E2);
    pwr_good = 1'b0;
    tick();
    chk("off_pad3", 32'(pad(3)), 32'h0000_E1C0);
    chk("off_io_ready", 32'(io_ready), 32'd0);
    chk("off_cfg_ready", 32'(cfg_ready), 32'd1);
    pwr_good = 1'b1;
    hold_req = 1'b0;
    tick();
    chk("replay_en_pad3", 32'(pad(3)), 32'h0000_E1E2);
    for (int k = 2; k <= 17; k++) begin
      tick();
      if (k == 16) chk("replay_io_ready_16", 32'(io_ready), 32'd0);
      if (k == 17) begin
        chk("replay_pad3", 32'(pad(3)), 32'h0000_E1E3);
        chk("replay_io_ready_17", 32'(io_ready), 32'd1);
      end
    end

    nreset = 1'b0;
    tick();
    chk("midrun_rst_pad3", 32'(pad(3)), 32'h0000_C000);
    chk("midrun_rst_pad2", 32'(pad(2)), 32'h0000_C000);
    chk("midrun_rst_io_ready", 32'(io_ready), 32'd0);
    chk("midrun_rst_cfg_ready", 32'(cfg_ready), 32'd0);
    nreset   = 1'b1;
    pwr_good = 1'b0;
    tick();
    chk("post_rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("post_rst_pad2", 32'(pad(2)), 32'h0000_C000);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
